// File: rtl/vga_fifo_rd_sched_pkg.sv
// ---------------------------------------------------------------------------
// vga_fifo_rd_sched_pkg
// Shared definitions for the VGA FIFO read scheduler:
//   - sched_state_e : scheduler FSM states
//   - VGA_*         : default 640x480 timing (pixels / lines)
//   - sof_bit_idx() : position of the start-of-frame tag bit in a FIFO word
// ---------------------------------------------------------------------------
package vga_fifo_rd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEEK     = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_RUN      = 2'd3
  } sched_state_e;

  localparam int VGA_DATA_W = 24;

  localparam int VGA_H_ACT = 640;
  localparam int VGA_H_FP  = 16;
  localparam int VGA_H_SYN = 96;
  localparam int VGA_H_BP  = 48;
  localparam int VGA_V_ACT = 480;
  localparam int VGA_V_FP  = 10;
  localparam int VGA_V_SYN = 2;
  localparam int VGA_V_BP  = 33;

  // The SOF tag sits directly above the pixel bits of a FIFO word.
  function automatic int sof_bit_idx(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/vga_fifo_rd_sched_if.sv
// ---------------------------------------------------------------------------
// vga_fifo_rd_sched_if
// First-word-fall-through FIFO read port.
//   fifo_empty    : head word invalid
//   fifo_rd_data  : head word, bit DATA_W is the SOF tag
//   fifo_rd_valid : pop, consumes the head at the clock edge
// Modports: master = reader (scheduler), slave = FIFO.
// ---------------------------------------------------------------------------
interface vga_fifo_rd_sched_if #(
  parameter int DATA_W = 24
) ();

  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rd_data;
  logic              fifo_rd_valid;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_valid
  );

endinterface

// File: rtl/vga_fifo_rd_sched_timing.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Horizontal / vertical raster counters and their decode.
// Ports:
//   rd_clk    : pixel clock
//   reset_rd  : asynchronous active-high reset
//   enable    : counters run while high, are forced to 0 while low
//   active    : current position is inside the visible area
//   hs_win    : current position is inside the horizontal sync window
//   vs_win    : current line is inside the vertical sync window
//   origin    : current position is (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_fifo_rd_sched_pkg::*;
#(
  parameter int H_ACT = VGA_H_ACT,
  parameter int H_FP  = VGA_H_FP,
  parameter int H_SYN = VGA_H_SYN,
  parameter int H_BP  = VGA_H_BP,
  parameter int V_ACT = VGA_V_ACT,
  parameter int V_FP  = VGA_V_FP,
  parameter int V_SYN = VGA_V_SYN,
  parameter int V_BP  = VGA_V_BP
) (
  input  logic rd_clk,
  input  logic reset_rd,
  input  logic enable,
  output logic active,
  output logic hs_win,
  output logic vs_win,
  output logic origin
);

  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;

  // One extra bit of headroom so the sync-window end (which equals the
  // total when the back porch is zero) is always representable.
  localparam int HW = $clog2(H_TOT + 1);
  localparam int VW = $clog2(V_TOT + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACTC = HW'(H_ACT);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACT + H_FP + H_SYN);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACTC = VW'(V_ACT);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACT + V_FP + V_SYN);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!enable) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge rd_clk or posedge reset_rd) begin
    if (reset_rd) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign active = (hcnt_q < H_ACTC) && (vcnt_q < V_ACTC);
  assign hs_win = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
  assign vs_win = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
  assign origin = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_fifo_rd_sched.sv
// ---------------------------------------------------------------------------
// vga_fifo_rd_sched
// Reads tagged pixel words from a first-word-fall-through FIFO and emits
// them on a VGA raster. A frame is only accepted when its SOF-tagged word
// lines up with raster position (0,0); any slip (underflow or tag in the
// wrong place) drops back to searching for the next SOF.
//
// Ports:
//   rd_clk, reset_rd  : pixel clock, asynchronous active-high reset
//   enable            : run request; low forces idle with counters at 0
//   fifo (master)     : FIFO read port (fifo_empty, fifo_rd_data, fifo_rd_valid)
//   hsync, vsync, de  : registered raster timing, latency 1
//   pixel             : registered pixel, 0 outside accepted frame data
//   frame_start       : pulse aligned with de of pixel (0,0) in RUN
//   underflow         : pulse, active position with FIFO empty in RUN
//   misalign          : pulse, SOF tag mismatch in RUN
//   underflow_count,
//   misalign_count    : saturating event counters
//
// Build option: VGA_SCHED_STATS_EN enables the event counters; without it
// both count ports are tied to 0.
//
// States:
//   IDLE     | enable low, counters held, nothing popped
//   SEEK     | discard untagged head words until an SOF word is at the head
//   WAIT_SOF | SOF at head, wait for raster (0,0) without popping
//   RUN      | pop one word per active pixel, checking tags
// ---------------------------------------------------------------------------
module vga_fifo_rd_sched
  import vga_fifo_rd_sched_pkg::*;
#(
  parameter int DATA_W = VGA_DATA_W,
  parameter int H_ACT  = VGA_H_ACT,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYN  = VGA_H_SYN,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_ACT  = VGA_V_ACT,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYN  = VGA_V_SYN,
  parameter int V_BP   = VGA_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic                rd_clk,
  input  logic                reset_rd,
  input  logic                enable,
  vga_fifo_rd_sched_if.master fifo,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [DATA_W-1:0]   pixel,
  output logic                frame_start,
  output logic                underflow,
  output logic                misalign,
  output logic [15:0]         underflow_count,
  output logic [15:0]         misalign_count
);

  localparam int SOF_BIT = sof_bit_idx(DATA_W);

  logic active, hs_win, vs_win, origin;

  vga_timing_gen #(
    .H_ACT (H_ACT),
    .H_FP  (H_FP),
    .H_SYN (H_SYN),
    .H_BP  (H_BP),
    .V_ACT (V_ACT),
    .V_FP  (V_FP),
    .V_SYN (V_SYN),
    .V_BP  (V_BP)
  ) u_timing (
    .rd_clk   (rd_clk),
    .reset_rd (reset_rd),
    .enable   (enable),
    .active   (active),
    .hs_win   (hs_win),
    .vs_win   (vs_win),
    .origin   (origin)
  );

  sched_state_e        state_q, state_d;
  logic                pop;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                de_q, de_d;
  logic [DATA_W-1:0]   pixel_q, pixel_d;
  logic                fs_q, fs_d;
  logic                uf_q, uf_d;
  logic                ma_q, ma_d;

  logic                head_sof;
  logic [DATA_W-1:0]   head_pix;

  assign head_sof = fifo.fifo_rd_data[SOF_BIT];
  assign head_pix = fifo.fifo_rd_data[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    hsync_d = ~HS_POL;
    vsync_d = ~VS_POL;
    de_d    = 1'b0;
    pixel_d = '0;
    fs_d    = 1'b0;
    uf_d    = 1'b0;
    ma_d    = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      hsync_d = hs_win ? HS_POL : ~HS_POL;
      vsync_d = vs_win ? VS_POL : ~VS_POL;
      de_d    = active;

      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEEK;
        end

        ST_SEEK: begin
          if (!fifo.fifo_empty) begin
            if (head_sof) state_d = ST_WAIT_SOF;
            else          pop     = 1'b1;
          end
        end

        // WAIT_SOF reaching (0,0) behaves as RUN in that same cycle, so the
        // SOF word is consumed as pixel (0,0) with no extra cycle of delay.
        ST_WAIT_SOF, ST_RUN: begin
          if (state_q == ST_RUN || origin) begin
            state_d = ST_RUN;
            if (active) begin
              if (fifo.fifo_empty) begin
                uf_d    = 1'b1;
                state_d = ST_SEEK;
              end else if (head_sof != origin) begin
                // Tag must be set exactly at (0,0) and clear elsewhere;
                // the offending word stays at the head for resync.
                ma_d    = 1'b1;
                state_d = ST_SEEK;
              end else begin
                pop     = 1'b1;
                pixel_d = head_pix;
                fs_d    = origin;
              end
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge reset_rd) begin
    if (reset_rd) begin
      state_q <= ST_IDLE;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      pixel_q <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      ma_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      pixel_q <= pixel_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      ma_q    <= ma_d;
    end
  end

  assign fifo.fifo_rd_valid = pop;
  assign hsync              = hsync_q;
  assign vsync              = vsync_q;
  assign de                 = de_q;
  assign pixel              = pixel_q;
  assign frame_start        = fs_q;
  assign underflow          = uf_q;
  assign misalign           = ma_q;

`ifdef VGA_SCHED_STATS_EN
  logic [15:0] uf_cnt_q, ma_cnt_q;

  // Counters step on the same edge that raises the matching pulse.
  always_ff @(posedge rd_clk or posedge reset_rd) begin
    if (reset_rd) begin
      uf_cnt_q <= '0;
      ma_cnt_q <= '0;
    end else begin
      if (uf_d && (uf_cnt_q != 16'hFFFF)) uf_cnt_q <= uf_cnt_q + 16'd1;
      if (ma_d && (ma_cnt_q != 16'hFFFF)) ma_cnt_q <= ma_cnt_q + 16'd1;
    end
  end

  assign underflow_count = uf_cnt_q;
  assign misalign_count  = ma_cnt_q;
`else
  assign underflow_count = 16'd0;
  assign misalign_count  = 16'd0;
`endif

endmodule

// File: tb/tb_vga_fifo_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_vga_fifo_rd_sched
// Directed bench for vga_fifo_rd_sched on a tiny 4x2 raster
// (H: 4+1+1+1 = 7, V: 2+1+1+1 = 5, 35 pixel clocks per frame).
// A raster-position model (frame position = enabled cycles mod 35) predicts
// every output each cycle; literal expectations pin key events.
// ---------------------------------------------------------------------------
module tb_vga_fifo_rd_sched;

  localparam int DW  = 8;
  localparam int HA  = 4, HFP = 1, HSY = 1, HBP = 1;
  localparam int VA  = 2, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FR  = HT * VT;

  localparam int M_IDLE = 0, M_SEEK = 1, M_WAIT = 2, M_RUN = 3;

  logic          clk = 1'b0;
  logic          reset_rd;
  logic          enable;
  logic          hsync, vsync, de, frame_start, underflow, misalign;
  logic [DW-1:0] pixel;
  logic [15:0]   underflow_count, misalign_count;

  vga_fifo_rd_sched_if #(.DATA_W(DW)) bus ();

  vga_fifo_rd_sched #(
    .DATA_W(DW), .H_ACT(HA), .H_FP(HFP), .H_SYN(HSY), .H_BP(HBP),
    .V_ACT(VA), .V_FP(VFP), .V_SYN(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .rd_clk          (clk),
    .reset_rd        (reset_rd),
    .enable          (enable),
    .fifo            (bus),
    .hsync           (hsync),
    .vsync           (vsync),
    .de              (de),
    .pixel           (pixel),
    .frame_start     (frame_start),
    .underflow       (underflow),
    .misalign        (misalign),
    .underflow_count (underflow_count),
    .misalign_count  (misalign_count)
  );

  initial forever #5 clk = ~clk;

  logic [DW:0]   fq[$];
  int            n_pass = 0, n_tot = 0;

  int            m_mode, m_k;
  logic          e_hs, e_vs, e_de, e_fs, e_uf, e_ma;
  logic [DW-1:0] e_pix;
  int            e_ufc, e_mac;

  int            n_pops, n_fs, n_uf, n_ma, fs_step, step_no;
  logic [DW-1:0] pix_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_k = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_pix = '0;
    e_fs = 1'b0; e_uf = 1'b0; e_ma = 1'b0;
    e_ufc = 0; e_mac = 0;
  endtask

  task automatic check_outputs();
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("de", 32'(de), 32'(e_de));
    chk("pixel", 32'(pixel), 32'(e_pix));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("misalign", 32'(misalign), 32'(e_ma));
`ifdef VGA_SCHED_STATS_EN
    chk("underflow_count", 32'(underflow_count), 32'(e_ufc));
    chk("misalign_count", 32'(misalign_count), 32'(e_mac));
`else
    chk("underflow_count", 32'(underflow_count), 32'd0);
    chk("misalign_count", 32'(misalign_count), 32'd0);
`endif
  endtask

  // One pixel clock: drive FIFO head, predict, compare, clock, compare.
  task automatic step();
    logic          rst_s, pop_s, exp_pop, act, org, emp, tag;
    logic [DW-1:0] d;
    int            h, v;
    bus.fifo_empty   = (fq.size() == 0);
    bus.fifo_rd_data = (fq.size() == 0) ? '0 : fq[0];
    #2;
    rst_s = reset_rd;
    pop_s = bus.fifo_rd_valid;
    if (rst_s) begin
      model_reset();
      check_outputs();
      chk("pop_in_reset", 32'(pop_s), 32'd0);
    end else begin
      exp_pop = 1'b0;
      e_fs = 1'b0; e_uf = 1'b0; e_ma = 1'b0; e_pix = '0;
      if (!enable) begin
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
        m_mode = M_IDLE; m_k = 0;
      end else begin
        h   = m_k % HT;
        v   = m_k / HT;
        act = (h < HA) && (v < VA);
        org = (h == 0) && (v == 0);
        emp = bus.fifo_empty;
        tag = bus.fifo_rd_data[DW];
        d   = bus.fifo_rd_data[DW-1:0];
        e_de = act;
        e_hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        e_vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        if (m_mode == M_WAIT && org) m_mode = M_RUN;
        case (m_mode)
          M_IDLE: m_mode = M_SEEK;
          M_SEEK: if (!emp) begin
                    if (tag) m_mode = M_WAIT;
                    else     exp_pop = 1'b1;
                  end
          M_RUN:  if (act) begin
                    if (emp) begin
                      e_uf = 1'b1; m_mode = M_SEEK;
                      if (e_ufc < 65535) e_ufc++;
                    end else if (tag != org) begin
                      e_ma = 1'b1; m_mode = M_SEEK;
                      if (e_mac < 65535) e_mac++;
                    end else begin
                      exp_pop = 1'b1; e_pix = d; e_fs = org;
                    end
                  end
          default: ;
        endcase
        m_k = (m_k + 1) % FR;
      end
      chk("fifo_rd_valid", 32'(pop_s), 32'(exp_pop));
    end
    @(posedge clk);
    #1;
    if (pop_s) begin
      if (fq.size() > 0) fq.delete(0);
      n_pops++;
    end
    if (!rst_s) begin
      check_outputs();
      if (de && pixel != '0) pix_log.push_back(pixel);
      if (frame_start) begin n_fs++; fs_step = step_no; end
      if (underflow) n_uf++;
      if (misalign) n_ma++;
    end
    step_no++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_word(input logic tag, input logic [DW-1:0] d);
    fq.push_back({tag, d});
  endtask

  task automatic push_frame(input logic [DW-1:0] base);
    push_word(1'b1, base);
    for (int i = 1; i < HA * VA; i++) push_word(1'b0, base + DW'(i));
  endtask

  task automatic clear_tallies();
    n_pops = 0; n_fs = 0; n_uf = 0; n_ma = 0; fs_step = -1; step_no = 0;
    pix_log.delete();
  endtask

  task automatic stop_run();
    enable = 1'b0;
    run(3);
  endtask

  initial begin
    reset_rd = 1'b0;
    enable   = 1'b0;
    model_reset();
    clear_tallies();
    #1;
    reset_rd = 1'b1;
    run(3);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    reset_rd = 1'b0;
    run(2);

    // Clean tagged frame: first pixel (0,0) is one full frame after enable.
    push_frame(8'h10);
    enable = 1'b1;
    clear_tallies();
    run(60);
    chk("s1_pops", n_pops, 8);
    chk("s1_frame_starts", n_fs, 1);
    chk("s1_fs_step", fs_step, 35);
    chk("s1_underflows", n_uf, 0);
    chk("s1_log_size", pix_log.size(), 8);
    chk("s1_first_pix", 32'(pix_log[0]), 32'h10);
    chk("s1_last_pix", 32'(pix_log[7]), 32'h17);
    stop_run();

    // Three untagged words ahead of the frame are discarded in SEEK.
    push_word(1'b0, 8'h01); push_word(1'b0, 8'h02); push_word(1'b0, 8'h03);
    push_frame(8'h20);
    enable = 1'b1;
    clear_tallies();
    run(60);
    chk("s2_pops", n_pops, 11);
    chk("s2_log_size", pix_log.size(), 8);
    chk("s2_first_pix", 32'(pix_log[0]), 32'h20);
    chk("s2_frame_starts", n_fs, 1);
    stop_run();

    // Writer stalls after 5 pixels; underflow at the 6th, recovery next frame.
    push_word(1'b1, 8'h30);
    for (int i = 1; i < 5; i++) push_word(1'b0, 8'h30 + 8'(i));
    enable = 1'b1;
    clear_tallies();
    run(46);
    push_frame(8'h40);
    run(54);
    chk("s3_underflows", n_uf, 1);
    chk("s3_frame_starts", n_fs, 2);
    chk("s3_pops", n_pops, 13);
    chk("s3_log_size", pix_log.size(), 13);
    chk("s3_pix4", 32'(pix_log[4]), 32'h34);
    chk("s3_pix5", 32'(pix_log[5]), 32'h40);
`ifdef VGA_SCHED_STATS_EN
    chk("s3_uf_count", 32'(underflow_count), 32'd1);
`else
    chk("s3_uf_count", 32'(underflow_count), 32'd0);
`endif
    stop_run();

    // SOF tag at pixel 3: misalign, word kept, it becomes the next (0,0).
    push_word(1'b1, 8'h50); push_word(1'b0, 8'h51); push_word(1'b0, 8'h52);
    push_word(1'b1, 8'h53);
    for (int i = 4; i < 11; i++) push_word(1'b0, 8'h50 + 8'(i));
    enable = 1'b1;
    clear_tallies();
    run(100);
    chk("s4_misaligns", n_ma, 1);
    chk("s4_underflows", n_uf, 0);
    chk("s4_pops", n_pops, 11);
    chk("s4_frame_starts", n_fs, 2);
    chk("s4_log_size", pix_log.size(), 11);
    chk("s4_pix2", 32'(pix_log[2]), 32'h52);
    chk("s4_pix3", 32'(pix_log[3]), 32'h53);
`ifdef VGA_SCHED_STATS_EN
    chk("s4_ma_count", 32'(misalign_count), 32'd1);
`else
    chk("s4_ma_count", 32'(misalign_count), 32'd0);
`endif
    stop_run();

    // Reset mid-line during RUN; leftover words are flushed by SEEK.
    push_frame(8'h60);
    enable = 1'b1;
    clear_tallies();
    run(38);
    reset_rd = 1'b1;
    run(1);
    chk("s5_hcnt", 32'(dut.u_timing.hcnt_q), 32'd0);
    chk("s5_vcnt", 32'(dut.u_timing.vcnt_q), 32'd0);
    chk("s5_de", 32'(de), 32'd0);
    chk("s5_vsync", 32'(vsync), 32'd1);
    chk("s5_pop", 32'(bus.fifo_rd_valid), 32'd0);
    chk("s5_uf_count", 32'(underflow_count), 32'd0);
    run(1);
    reset_rd = 1'b0;
    push_frame(8'h70);
    clear_tallies();
    run(60);
    chk("s5_pops", n_pops, 13);
    chk("s5_log_size", pix_log.size(), 8);
    chk("s5_first_pix", 32'(pix_log[0]), 32'h70);
    stop_run();

    // Enable dropped mid-line: inactive outputs and zeroed counters next edge.
    push_frame(8'h80);
    enable = 1'b1;
    clear_tallies();
    run(37);
    enable = 1'b0;
    run(1);
    chk("s6_de", 32'(de), 32'd0);
    chk("s6_hsync", 32'(hsync), 32'd1);
    chk("s6_pixel", 32'(pixel), 32'd0);
    chk("s6_hcnt", 32'(dut.u_timing.hcnt_q), 32'd0);
    chk("s6_vcnt", 32'(dut.u_timing.vcnt_q), 32'd0);
    chk("s6_pop", 32'(bus.fifo_rd_valid), 32'd0);
    chk("s6_pops", n_pops, 2);
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vga_fifo_rd_sched.md
VGA_FIFO_RD_SCHED -- requirements
Module: vga_fifo_rd_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width excluding tag bit.
REQ-002 SHALL have parameters H_ACT 640, H_FP 16, H_SYN 96, H_BP 48, V_ACT 480, V_FP 10, V_SYN 2, V_BP 33, giving VGA timing in pixels and lines.
REQ-003 SHALL have parameters HS_POL 0 and VS_POL 0, the active sync level.
REQ-004 SHALL have ports: rd_clk in 1, pixel clock; reset_rd in 1, asynchronous active-high reset.
REQ-005 SHALL have ports: enable in 1, run request; fifo_empty in 1, FIFO head invalid; fifo_rd_data in DATA_W+1, head word with bit DATA_W as SOF tag.
REQ-006 SHALL have ports: fifo_rd_valid out 1, pop; hsync out 1; vsync out 1; de out 1; pixel out DATA_W.
REQ-007 SHALL have ports: frame_start out 1, pulse; underflow out 1, pulse; misalign out 1, pulse; underflow_count out 16; misalign_count out 16.

Function
REQ-008 SHALL treat the FIFO as first-word-fall-through: fifo_rd_data is valid while fifo_empty=0, and fifo_rd_valid=1 consumes it at that edge.
REQ-009 SHALL run hcnt 0..H_TOT-1 and vcnt 0..V_TOT-1 while enable=1; hcnt wraps to 0 and increments vcnt; vcnt wraps at V_TOT-1 with hcnt wrap. H_TOT and V_TOT are sums of the respective parameters.
REQ-010 SHALL define active = hcnt<H_ACT && vcnt<V_ACT; sync windows start at H_ACT+H_FP and V_ACT+V_FP with widths H_SYN and V_SYN.
REQ-011 SHALL register hsync, vsync, de and pixel one cycle after the counter state that produced them; fixed latency 1 for all four.
REQ-012 SHALL implement states IDLE, SEEK, WAIT_SOF and RUN.
REQ-013 IDLE: enable=0 -> counters held at 0, no pops; enable=1 -> SEEK.
REQ-014 SEEK: if head valid without SOF -> pop and discard; if head valid with SOF -> WAIT_SOF without popping.
REQ-015 WAIT_SOF: no pops; at hcnt=0 and vcnt=0 -> RUN, and that cycle is treated as RUN.
REQ-016 RUN: fifo_rd_valid = active && ~fifo_empty && tag check passes.
REQ-016a RUN: pixel = popped data; pixel = 0 when not active.
REQ-017 RUN tag check: at (0,0) the head SOF tag must be 1; at any other active position it must be 0.
REQ-017a RUN tag violation: misalign pulses one cycle, no pop, pixel 0, -> SEEK.
REQ-018 RUN: active with fifo_empty=1 -> underflow pulses one cycle, pixel 0, -> SEEK; underflow takes priority over misalign.
REQ-019 frame_start SHALL pulse with the de of pixel (0,0) in RUN only.
REQ-020 In SEEK and WAIT_SOF, timing outputs continue, de follows active, and pixel = 0.
REQ-021 enable falling SHALL force IDLE on the next edge, zero the counters, drive inactive outputs, and stop popping; any state.

Reset
REQ-022 reset_rd SHALL force: state IDLE, counters 0, hsync=~HS_POL, vsync=~VS_POL, de=0, pixel=0, fifo_rd_valid=0, all pulses 0, both counts 0.
REQ-023 Reset mid-frame SHALL abandon the frame; after release, resync uses SEEK only.

Configuration
REQ-024 With VGA_SCHED_STATS_EN defined, underflow_count and misalign_count SHALL increment on their pulses, saturate at 16'hFFFF, and clear only on reset.
REQ-025 Without VGA_SCHED_STATS_EN, both count ports SHALL be driven constant 0 and no counter registers SHALL exist; pulses are unaffected.

Structure
REQ-026 A shared package SHALL hold the state enum, the default VGA 640x480 timing constants and the SOF tag bit index.
REQ-027 A sub-module vga_timing_gen SHALL hold the counters and the active and sync decode; the scheduler FSM and stats SHALL stay in the top.

Verification
REQ-028 FIFO prefilled with a tagged 4x2 frame (H_ACT=4, V_ACT=2, small porches), enable=1 -> first frame_start at (0,0), 8 pixels match data in order, no underflow.
REQ-029 Three untagged words, then a tagged frame -> exactly 3 discard pops in SEEK, then normal frame output.
REQ-030 Writer stalls after 5 of 8 pixels -> underflow pulses once at the 6th pixel, remaining pixels 0, recovery on the next tagged frame, underflow_count=1 with the macro.
REQ-031 SOF tag injected at pixel 3 -> misalign pulses, that word is not popped, and output resumes at the next frame boundary with that word as pixel (0,0).
REQ-032 reset_rd asserted mid-line, and separately enable dropped mid-line -> outputs reach the reset or inactive values as specified, fifo_rd_valid=0 and counters 0.
